uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART transmitter (uart core: transmit/tx_byte/is_transmitting) among N_REQ
//  message sources (e.g. sequence dump, result print, debug echo). Grants round-robin and
//  streams each granted source's NUL-terminated byte buffer, one byte per UART handshake.
//  Sits between the top-level print FSMs and the uart instance, replacing per-source send logic.
// PARAMETERS
//  N_REQ    2       number of requesters (2..8)
//  MAX_LEN  32      max bytes per message excluding terminator; IDX_W = $clog2(MAX_LEN+1)
//  WAIT_TO  100000  cycles allowed in S_WAIT for is_transmitting to rise before abort
// PORTS
//  clk                  in   1          system clock
//  reset_n              in   1          synchronous, active-low reset
//  req                  in   N_REQ      level request per source; sampled only in S_IDLE
//  msg_data             in   N_REQ*8    byte of source i at rd_idx, slice [8i+7:8i], combinational
//  rd_idx               out  IDX_W      byte index into the granted buffer
//  grant                out  N_REQ      one-hot owner of the UART; 0 when idle
//  done                 out  N_REQ      1-cycle pulse to the owner when its message completes
//  err                  out  1          1-cycle pulse on WAIT_TO abort
//  busy                 out  1          high in every state except S_IDLE
//  uart_transmit        out  1          transmit strobe to uart core
//  uart_tx_byte         out  8          byte to uart core
//  uart_is_transmitting in   1          uart core busy flag
// BEHAVIOUR
//  - Reset: state S_IDLE, grant=0, done=0, err=0, busy=0, rd_idx=0, uart_transmit=0,
//    uart_tx_byte=8'h00, rr pointer=0. Reset mid-message drops transmit the next edge; no done.
//  - States: S_IDLE, S_LOAD, S_WAIT, S_SEND, S_INCR, S_DONE.
//  - S_IDLE: if |req, pick first set bit scanning from ptr upward (wrap); register grant,
//    rd_idx<=0 -> S_LOAD. Latency req->grant = 1 cycle.
//  - S_LOAD: tx_byte <= owner msg_data slice. Byte 8'h00 or rd_idx==MAX_LEN -> S_DONE
//    (zero-length message: no transmit, done still pulses); else -> S_WAIT.
//  - S_WAIT: uart_transmit=1; is_transmitting==1 -> S_SEND; counter reaching WAIT_TO ->
//    err pulse, -> S_DONE without done pulse.
//  - S_SEND: uart_transmit=0; is_transmitting==0 -> S_INCR.
//  - S_INCR: rd_idx<=rd_idx+1 -> S_LOAD. rd_idx never exceeds MAX_LEN (no wrap).
//  - S_DONE: done[owner] pulses (unless abort); ptr <= owner+1 mod N_REQ; grant<=0 -> S_IDLE.
//  - req deassert while granted is ignored; message runs to completion.
//  - Simultaneous requests: round-robin; a source re-requesting immediately waits behind others.
//  - uart_tx_byte holds its value from S_LOAD through S_SEND.
// CONFIGURATION
//  UART_ARB_CRLF_EN defined: on terminator/MAX_LEN, S_LOAD inserts 8'h0D then 8'h0A through
//    the normal WAIT/SEND/INCR handshake before S_DONE (tracked by a 2-bit suffix counter).
//  Undefined: message sent byte-exact; sources supply their own CR/LF.
// STRUCTURE
//  uart_arb_pkg: state encoding localparams, ASCII_NUL/CR/LF constants.
//  Sub-module rr_arbiter (req, ptr -> one-hot grant, combinational) instantiated once.
// TESTING
//  1 reset, req=2'b01, src0 "AB\0" -> tx 8'h41,8'h42; done[0] once; grant back to 0.
//  2 req=2'b11 from idle, both "X\0" -> src0 served first, then src1; ptr=0 after.
//  3 src1 buffer first byte 8'h00 -> no uart_transmit, done[1] pulse 2 cycles after grant.
//  4 MAX_LEN=4, src0 "ABCDEFG" no NUL -> exactly 4 bytes "ABCD", then done[0].
//  5 uart model never raises is_transmitting -> err after WAIT_TO cycles, no done, S_IDLE.
//  6 reset_n low during 2nd byte of 5 -> transmit low next edge; all outputs at reset values.
//  7 UART_ARB_CRLF_EN on, "7\0" -> bytes 8'h37,8'h0D,8'h0A then done.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and
// the ASCII control bytes used for message termination and line endings.
package uart_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_WAIT = 3'd2,
        S_SEND = 3'd3,
        S_INCR = 3'd4,
        S_DONE = 3'd5
    } arb_state_e;

    localparam logic [7:0] ASCII_NUL = 8'h00;
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: returns a one-hot grant for the first
// set request found scanning upward from ptr_i, wrapping at N_REQ.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int PTR_W = 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o
);

    logic found;

    // Scan offsets 0..N_REQ-1 from the pointer; the first hit wins.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!found && req_i[i] && (((int'(ptr_i) + k) % N_REQ) == i)) begin
                    gnt_o[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ message sources. Sources are granted
// round-robin and each granted source's NUL-terminated buffer is streamed one
// byte per UART handshake, capped at MAX_LEN bytes.
// Optional feature macro: UART_ARB_CRLF_EN appends CR, LF after every message.
//
// UART handshake: the arbiter holds uart_transmit high with uart_tx_byte
// stable until the core raises uart_is_transmitting (byte accepted), then
// drops uart_transmit and waits for uart_is_transmitting to fall before the
// next byte. If the core never responds within WAIT_TO cycles the message is
// aborted with an err pulse and no done pulse.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int N_REQ   = 2,
    parameter  int MAX_LEN = 32,
    parameter  int WAIT_TO = 100000,
    localparam int IDX_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*8-1:0] msg_data,
    output logic [IDX_W-1:0]   rd_idx,
    output logic [N_REQ-1:0]   grant,
    output logic [N_REQ-1:0]   done,
    output logic               err,
    output logic               busy,
    output logic               uart_transmit,
    output logic [7:0]         uart_tx_byte,
    input  logic               uart_is_transmitting,
    output logic [2:0]         dbg_state
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(WAIT_TO + 1);
    localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_TO - 1);
    localparam logic [PTR_W-1:0] OWN_LAST  = PTR_W'(N_REQ - 1);

    arb_state_e         state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
    logic [7:0]         tx_byte_q, tx_byte_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               abort_q, abort_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               err_q, err_d;
`ifdef UART_ARB_CRLF_EN
    logic [1:0]         sfx_q, sfx_d;
`endif

    logic [N_REQ-1:0]   arb_gnt;
    logic [PTR_W-1:0]   arb_idx;
    logic [7:0]         cur_byte;
    logic               end_msg;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt)
    );

    // Encode the arbiter's one-hot pick and select the owner's current byte.
    always_comb begin
        arb_idx  = '0;
        cur_byte = ASCII_NUL;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_gnt[i]) arb_idx = PTR_W'(i);
            if (owner_q == PTR_W'(i)) cur_byte = msg_data[i*8 +: 8];
        end
        end_msg = (cur_byte == ASCII_NUL) || (rd_idx_q == IDX_MAX);
    end

    // Next-state and datapath updates for the message streaming FSM.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        rd_idx_d   = rd_idx_q;
        tx_byte_d  = tx_byte_q;
        wait_cnt_d = '0;
        abort_d    = abort_q;
        done_d     = '0;
        err_d      = 1'b0;
`ifdef UART_ARB_CRLF_EN
        sfx_d      = sfx_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    grant_d  = arb_gnt;
                    owner_d  = arb_idx;
                    rd_idx_d = '0;
                    abort_d  = 1'b0;
`ifdef UART_ARB_CRLF_EN
                    sfx_d    = 2'd0;
`endif
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
`ifdef UART_ARB_CRLF_EN
                if (sfx_q == 2'd0 && !end_msg) begin
                    tx_byte_d = cur_byte;
                    state_d   = S_WAIT;
                end else if (sfx_q == 2'd0) begin
                    tx_byte_d = ASCII_CR;
                    sfx_d     = 2'd1;
                    state_d   = S_WAIT;
                end else if (sfx_q == 2'd1) begin
                    tx_byte_d = ASCII_LF;
                    sfx_d     = 2'd2;
                    state_d   = S_WAIT;
                end else begin
                    state_d   = S_DONE;
                end
`else
                tx_byte_d = cur_byte;
                state_d   = end_msg ? S_DONE : S_WAIT;
`endif
            end
            S_WAIT: begin
                if (uart_is_transmitting) begin
                    state_d = S_SEND;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    abort_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_SEND: begin
                if (!uart_is_transmitting) state_d = S_INCR;
            end
            S_INCR: begin
`ifdef UART_ARB_CRLF_EN
                if (sfx_q == 2'd0 && rd_idx_q != IDX_MAX) rd_idx_d = rd_idx_q + 1'b1;
`else
                if (rd_idx_q != IDX_MAX) rd_idx_d = rd_idx_q + 1'b1;
`endif
                state_d = S_LOAD;
            end
            S_DONE: begin
                done_d  = abort_q ? '0 : grant_q;
                err_d   = abort_q;
                ptr_d   = (owner_q == OWN_LAST) ? '0 : owner_q + 1'b1;
                grant_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            ptr_q      <= '0;
            rd_idx_q   <= '0;
            tx_byte_q  <= ASCII_NUL;
            wait_cnt_q <= '0;
            abort_q    <= 1'b0;
            done_q     <= '0;
            err_q      <= 1'b0;
`ifdef UART_ARB_CRLF_EN
            sfx_q      <= 2'd0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            rd_idx_q   <= rd_idx_d;
            tx_byte_q  <= tx_byte_d;
            wait_cnt_q <= wait_cnt_d;
            abort_q    <= abort_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef UART_ARB_CRLF_EN
            sfx_q      <= sfx_d;
`endif
        end
    end

    assign rd_idx        = rd_idx_q;
    assign grant         = grant_q;
    assign done          = done_q;
    assign err           = err_q;
    assign busy          = (state_q != S_IDLE);
    assign uart_transmit = (state_q == S_WAIT);
    assign uart_tx_byte  = tx_byte_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: randomized source buffers and request masks,
// a behavioural UART core, and a token scoreboard (bytes, done, err).
module tb_uart_tx_arbiter;

  localparam int N_REQ   = 2;
  localparam int MAX_LEN = 4;
  localparam int WAIT_TO = 20;
  localparam int IDX_W   = $clog2(MAX_LEN + 1);
  localparam int W       = 16;
`ifdef UART_ARB_CRLF_EN
  localparam bit CRLF = 1'b1;
`else
  localparam bit CRLF = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset_n;
  logic [N_REQ-1:0]   req;
  logic [N_REQ*8-1:0] msg_data;
  logic [IDX_W-1:0]   rd_idx;
  logic [N_REQ-1:0]   grant;
  logic [N_REQ-1:0]   done;
  logic               err;
  logic               busy;
  logic               uart_transmit;
  logic [7:0]         uart_tx_byte;
  logic               uart_is_transmitting;
  logic [2:0]         dbg_state;

  uart_tx_arbiter #(
    .N_REQ   (N_REQ),
    .MAX_LEN (MAX_LEN),
    .WAIT_TO (WAIT_TO)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .req                  (req),
    .msg_data             (msg_data),
    .rd_idx               (rd_idx),
    .grant                (grant),
    .done                 (done),
    .err                  (err),
    .busy                 (busy),
    .uart_transmit        (uart_transmit),
    .uart_tx_byte         (uart_tx_byte),
    .uart_is_transmitting (uart_is_transmitting),
    .dbg_state            (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [7:0]   buf_mem [N_REQ][MAX_LEN+1];
  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           model_ptr = 0;
  bit           uart_alive = 1'b1;
  int           hs_cnt = 0;
  int           tx_run = 0;
  int           last_run = 0;

  // source buffers, read combinationally at rd_idx
  always_comb begin
    msg_data = '0;
    for (int i = 0; i < N_REQ; i++)
      msg_data[i*8 +: 8] = (int'(rd_idx) <= MAX_LEN) ? buf_mem[i][rd_idx] : 8'h00;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_tok(input string name, input logic [W-1:0] tok);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s unexpected: got %0h expected nothing", name, tok);
    end else begin
      check(name, tok, exp_q.pop_front());
    end
  endtask

  function automatic logic [3:0] src_of(input logic [N_REQ-1:0] g);
    logic [3:0] s = 4'd0;
    for (int i = 0; i < N_REQ; i++) if (g[i]) s = 4'(i);
    return s;
  endfunction

  // behavioural UART core: accepts a strobe after a random delay, stays busy a while
  initial begin : uart_model
    int lat;
    int hold;
    uart_is_transmitting = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (uart_transmit && uart_alive) begin
        lat = $urandom_range(0, 2);
        for (int i = 0; i < lat; i++) begin @(posedge clk); #2; end
        uart_is_transmitting = 1'b1;
        hold = $urandom_range(1, 4);
        for (int i = 0; i < hold; i++) begin @(posedge clk); #2; end
        uart_is_transmitting = 1'b0;
      end
    end
  end

  // monitor: turns DUT activity into tokens and compares them with the expected queue
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (uart_transmit) tx_run++;
      else begin
        if (tx_run != 0) last_run = tx_run;
        tx_run = 0;
      end
      if (reset_n) begin
        if (uart_transmit && uart_is_transmitting) begin
          hs_cnt++;
          expect_tok("byte", {4'd1, src_of(grant), uart_tx_byte});
        end
        for (int i = 0; i < N_REQ; i++)
          if (done[i]) expect_tok("done", {4'd2, 4'(i), 8'h00});
        if (err) expect_tok("err", {4'd3, 4'd0, 8'h00});
      end
    end
  end

  // reference model: what one granted source should produce
  task automatic push_msg(input int s);
    int n = 0;
    while (n < MAX_LEN && buf_mem[s][n] != 8'h00) n++;
    if (!uart_alive && (n > 0 || CRLF)) begin
      exp_q.push_back({4'd3, 4'd0, 8'h00});
    end else begin
      for (int i = 0; i < n; i++) exp_q.push_back({4'd1, 4'(s), buf_mem[s][i]});
      if (CRLF) begin
        exp_q.push_back({4'd1, 4'(s), 8'h0D});
        exp_q.push_back({4'd1, 4'(s), 8'h0A});
      end
      exp_q.push_back({4'd2, 4'(s), 8'h00});
    end
  endtask

  // reference model: round-robin service order for a request mask held until granted
  task automatic plan(input logic [N_REQ-1:0] mask, output logic [N_REQ-1:0] first);
    logic [N_REQ-1:0] pend = mask;
    int s = 0;
    first = '0;
    while (pend != '0) begin
      for (int k = 0; k < N_REQ; k++) begin
        s = (model_ptr + k) % N_REQ;
        if (pend[s]) break;
      end
      if (first == '0) first[s] = 1'b1;
      push_msg(s);
      pend[s] = 1'b0;
      model_ptr = (s + 1) % N_REQ;
    end
  endtask

  task automatic fill_str(input int s, input string str);
    for (int i = 0; i <= MAX_LEN; i++)
      buf_mem[s][i] = (i < str.len()) ? str[i] : 8'h00;
  endtask

  task automatic fill_rand(input int s);
    int len = $urandom_range(0, MAX_LEN + 1);
    for (int i = 0; i <= MAX_LEN; i++)
      buf_mem[s][i] = (i < len) ? 8'($urandom_range(1, 255)) : 8'h00;
  endtask

  task automatic drain(input string name, input int budget);
    int c = 0;
    while ((exp_q.size() != 0 || busy) && c < budget) begin
      @(negedge clk);
      req &= ~grant;
      c++;
    end
    check({name, " drained"}, (exp_q.size() == 0 && !busy) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic run_batch(input string name, input logic [N_REQ-1:0] mask);
    logic [N_REQ-1:0] first;
    plan(mask, first);
    @(negedge clk);
    req = mask;
    @(negedge clk);
    check({name, " grant"}, grant, first);
    check({name, " busy"}, busy, 1);
    req &= ~grant;
    drain(name, 400);
    check({name, " grant idle"}, grant, 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " grant"}, grant, 0);
    check({name, " done"}, done, 0);
    check({name, " err"}, err, 0);
    check({name, " busy"}, busy, 0);
    check({name, " rd_idx"}, rd_idx, 0);
    check({name, " transmit"}, uart_transmit, 0);
    check({name, " tx_byte"}, uart_tx_byte, 0);
    check({name, " state"}, dbg_state, 0);
  endtask

  initial begin : watchdog
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin : main
    logic [N_REQ-1:0] first;
    int base;
    int c;
    reset_n = 1'b0;
    req     = '0;
    fill_str(0, "");
    fill_str(1, "");
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // single source, two bytes
    fill_str(0, "AB");
    run_batch("ab", 2'b01);

    // both request from idle
    fill_str(0, "X");
    fill_str(1, "X");
    run_batch("both", 2'b11);

    // zero-length message on src1: no transmit, done two cycles after grant
    fill_str(1, "");
    plan(2'b10, first);
    @(negedge clk);
    req = 2'b10;
    @(negedge clk);
    check("zl grant", grant, 2'b10);
    req = '0;
    @(negedge clk);
    check("zl done early", done, 0);
    check("zl transmit", uart_transmit, 0);
    @(negedge clk);
    check("zl done", done, 2'b10);
    check("zl grant idle", grant, 0);
    drain("zl", 50);

    // no terminator within MAX_LEN
    fill_str(0, "ABCDE");
    run_batch("maxlen", 2'b01);

    // randomized traffic
    for (int t = 0; t < 30; t++) begin
      fill_rand(0);
      fill_rand(1);
      run_batch("rand", 2'($urandom_range(1, 3)));
    end

    // UART core never responds: abort
    uart_alive = 1'b0;
    fill_str(0, "Z");
    run_batch("abort", 2'b01);
    check("abort wait cycles", last_run, WAIT_TO);
    check("abort state", dbg_state, 0);
    uart_alive = 1'b1;
    repeat (2) @(negedge clk);

    // reset during the second byte of a message
    fill_str(1, "QRSTU");
    plan(2'b10, first);
    @(negedge clk);
    req = 2'b10;
    base = hs_cnt;
    c = 0;
    while (!(hs_cnt == base + 1 && uart_transmit && !uart_is_transmitting) && c < 200) begin
      @(negedge clk);
      req &= ~grant;
      c++;
    end
    check("midreset reached byte 2", (c < 200) ? 32'd1 : 32'd0, 32'd1);
    reset_n = 1'b0;
    req = '0;
    @(negedge clk);
    check_reset_outputs("midreset");
    exp_q.delete();
    model_ptr = 0;
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("midreset no done", done, 0);

    // arbitration restarts from source 0 after reset
    fill_rand(0);
    fill_rand(1);
    run_batch("post reset", 2'b11);

    repeat (5) @(negedge clk);
    check("final queue empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
